// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

    localparam int ADDR_W            = 64;
    localparam int INSTR_W           = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] u32;

    typedef struct packed {
        addr_t pc;
        u32    raw_instr;
    } fetch_queue_entry_t;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_chk.sv
// Occupancy/pointer consistency checks for fetch_queue.
module fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             reset,
    input logic [PTR_W-1:0] wr_ptr_i,
    input logic [PTR_W-1:0] rd_ptr_i,
    input logic [PTR_W:0]   count_i,
    input logic             we_i,
    input logic             rd_adv_i
);

    logic [PTR_W-1:0] ptr_diff_s;

    // Pointer distance modulo DEPTH
    always_comb begin
        ptr_diff_s = wr_ptr_i - rd_ptr_i;
    end

    a_count_matches_ptrs : assert property (@(posedge clk) disable iff (reset)
        ({1'b0, ptr_diff_s} == count_i) ||
        ((count_i == (PTR_W+1)'(DEPTH)) && (wr_ptr_i == rd_ptr_i)));

    a_no_write_when_full : assert property (@(posedge clk) disable iff (reset)
        !(we_i && (count_i == (PTR_W+1)'(DEPTH))));

    a_no_read_when_empty : assert property (@(posedge clk) disable iff (reset)
        !(rd_adv_i && (count_i == (PTR_W+1)'(0))));

endmodule : fetch_queue_chk

// File: rtl/fetch_queue_mem.sv
// Entry register file: one write port, one asynchronous read port, contents never cleared.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  fetch_queue_entry_t wdata_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output fetch_queue_entry_t rdata_o
);

    fetch_queue_entry_t storage_q [DEPTH];

    // Entry write on enqueue
    always_ff @(posedge clk) begin
        if (we_i) begin
            storage_q[waddr_i] <= wdata_i;
        end
    end

    // Head read straight from the registers
    always_comb begin
        rdata_o = storage_q[raddr_i];
    end

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue; flush and reset drop all entries, outputs come only from state.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_pc,
    input  logic [INSTR_W-1:0]     in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               enq_s, deq_s, we_s;
    fetch_queue_entry_t wr_entry_s, rd_entry_s;

    // Handshakes and next-state; flush overrides any concurrent enq/deq
    always_comb begin
        in_ready   = (count_q != CNT_W'(DEPTH));
        out_valid  = (count_q != CNT_W'(0));
        enq_s      = in_valid && in_ready;
        deq_s      = out_valid && out_ready;
        we_s       = enq_s && !flush && !reset;
        wr_entry_s = '{pc: in_pc, raw_instr: in_instr};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy state, reset wins over flush
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry_s)
    );

    // Head data, forced to zero while empty so reset state is deterministic
    always_comb begin
        count = count_q;
        if (out_valid) begin
            out_pc    = rd_entry_s.pc;
            out_instr = rd_entry_s.raw_instr;
        end else begin
            out_pc    = ADDR_W'(0);
            out_instr = INSTR_W'(0);
        end
    end

    fetch_queue_chk #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .wr_ptr_i (wr_ptr_q),
        .rd_ptr_i (rd_ptr_q),
        .count_i  (count_q),
        .we_i     (we_s),
        .rd_adv_i (deq_s && !flush)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed scenario bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        n_cmp++;
        if (count !== 3'd0) begin
            n_err++;
            $display("FAIL %s_count: got %0d want 0", tag, count);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_out_valid: got %b want 0", tag, out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_in_ready: got %b want 1", tag, in_ready);
        end
    endtask

    task automatic enq_n(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pc    = base + 64'(4 * i);
            in_instr = 32'h0000_0100 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_empty("reset");
        end
        reset = 1'b0;
        tick();
        chk_empty("idle");
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL fill_in_ready_%0d: got %b want 1", i, in_ready);
            end
            in_valid = 1'b1;
            in_pc    = 64'h0000_0000_8000_0000 + 64'(4 * i);
            in_instr = 32'h0000_0013 + 32'(i);
            tick();
        end
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL fill_count: got %0d want 4", count);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_in_ready_full: got %b want 0", in_ready);
        end
        in_pc    = 64'h0000_0000_8000_0010;
        in_instr = 32'h0000_0017;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL fill_fifth_ignored: got count %0d want 4", count);
        end
        n_cmp++;
        if (out_pc !== 64'h0000_0000_8000_0000 || out_instr !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL fill_head: got %h/%h want 80000000/00000013", out_pc, out_instr);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 64'h0000_0000_8000_0000 + 64'(4 * i)
                || out_instr !== 32'h0000_0013 + 32'(i)) begin
                n_err++;
                $display("FAIL drain_%0d: got v=%b %h/%h want v=1 %h/%h", i, out_valid, out_pc,
                         out_instr, 64'h0000_0000_8000_0000 + 64'(4 * i), 32'h0000_0013 + 32'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        chk_empty("drain_done");
    endtask

    task automatic test_wrap_simul();
        logic [63:0] base;
        base = 64'h0000_0000_8000_0100;
        out_ready = 1'b0;
        enq_n(base, 2);
        for (int k = 0; k < 10; k++) begin
            in_valid  = 1'b1;
            in_pc     = base + 64'(4 * (k + 2));
            in_instr  = 32'h0000_0200 + 32'(k);
            out_ready = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== base + 64'(4 * k)) begin
                n_err++;
                $display("FAIL wrap_head_%0d: got v=%b %h want v=1 %h", k, out_valid, out_pc,
                         base + 64'(4 * k));
            end
            tick();
            n_cmp++;
            if (count !== 3'd2) begin
                n_err++;
                $display("FAIL wrap_count_%0d: got %0d want 2", k, count);
            end
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            n_cmp++;
            if (out_pc !== base + 64'(4 * k)) begin
                n_err++;
                $display("FAIL wrap_tail_%0d: got %h want %h", k, out_pc, base + 64'(4 * k));
            end
            tick();
        end
        out_ready = 1'b0;
        chk_empty("wrap_done");
    endtask

    task automatic test_flush();
        enq_n(64'h0000_0000_8000_0200, 3);
        n_cmp++;
        if (count !== 3'd3) begin
            n_err++;
            $display("FAIL flush_pre_count: got %0d want 3", count);
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'h0000_0000_8000_1000;
        in_instr  = 32'h0000_1000;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_empty("flush");
        n_cmp++;
        if (out_pc === 64'h0000_0000_8000_1000) begin
            n_err++;
            $display("FAIL flush_dropped: got %h want not 80001000", out_pc);
        end
        enq_n(64'h0000_0000_8000_2000, 1);
        n_cmp++;
        if (count !== 3'd1 || out_pc !== 64'h0000_0000_8000_2000) begin
            n_err++;
            $display("FAIL flush_after: got count %0d pc %h want 1 80002000", count, out_pc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_empty("flush_drain");
    endtask

    task automatic test_reset_midop();
        enq_n(64'h0000_0000_8000_0300, 2);
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_pc    = 64'h0000_0000_8000_0400;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_empty("reset_midop");
        in_valid = 1'b1;
        in_pc    = 64'h0000_0000_8000_0000;
        in_instr = 32'h0000_0099;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0000_0000_8000_0000
            || out_instr !== 32'h0000_0099 || count !== 3'd1) begin
            n_err++;
            $display("FAIL reset_post_enq: got v=%b %h/%h c=%0d want v=1 80000000/00000099 c=1",
                     out_valid, out_pc, out_instr, count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 64'h0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap_simul();
        test_flush();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_queue
